// File: rtl/led_input_ctrl.sv
// led_input_ctrl: debounced toggle buttons for en/speed plus a rate-selectable step pulse.
// Macro LED_INPUT_DBNC_FILTER_EN enables the 4-sample history filter; without it history is 1 sample.
module led_input_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int STEP_W   = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_en,
    input  logic       btn_speed,
    output logic       en,
    output logic       speed,
    output logic       step,
    output logic       en_press,
    output logic       speed_press,
    output logic [1:0] dbg_state
);
`ifdef LED_INPUT_DBNC_FILTER_EN
    localparam int HIST_W = 4;
`else
    localparam int HIST_W = 1;
`endif

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} btn_state_t;

    logic [1:0]          r_en_sync;
    logic [1:0]          r_sp_sync;
    logic [SAMPLE_W-1:0] r_sample_cnt;
    logic [HIST_W-1:0]   r_en_hist;
    logic [HIST_W-1:0]   r_sp_hist;
    btn_state_t          r_en_state;
    btn_state_t          r_sp_state;
    logic                r_en;
    logic                r_speed;
    logic                r_en_press;
    logic                r_sp_press;
    logic [STEP_W:0]     r_step_cnt;
    logic                r_step;

    logic w_tick;
    logic w_en_full;
    logic w_en_empty;
    logic w_sp_full;
    logic w_sp_empty;
    logic w_step_hit;

    assign w_tick     = &r_sample_cnt;
    assign w_en_full  = &r_en_hist;
    assign w_en_empty = ~|r_en_hist;
    assign w_sp_full  = &r_sp_hist;
    assign w_sp_empty = ~|r_sp_hist;

    // Synchronizers, sample counter and history shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_sync    <= '0;
            r_sp_sync    <= '0;
            r_sample_cnt <= '0;
            r_en_hist    <= '0;
            r_sp_hist    <= '0;
        end else begin
            r_en_sync    <= {r_en_sync[0], btn_en};
            r_sp_sync    <= {r_sp_sync[0], btn_speed};
            r_sample_cnt <= r_sample_cnt + 1'b1;
            if (w_tick) begin
`ifdef LED_INPUT_DBNC_FILTER_EN
                r_en_hist <= {r_en_hist[HIST_W-2:0], r_en_sync[1]};
                r_sp_hist <= {r_sp_hist[HIST_W-2:0], r_sp_sync[1]};
`else
                r_en_hist <= r_en_sync[1];
                r_sp_hist <= r_sp_sync[1];
`endif
            end
        end
    end

    // Press FSMs: the pulse and the output toggle share the edge that enters PRESSED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_state <= RELEASED;
            r_sp_state <= RELEASED;
            r_en       <= 1'b0;
            r_speed    <= 1'b0;
            r_en_press <= 1'b0;
            r_sp_press <= 1'b0;
        end else begin
            r_en_press <= 1'b0;
            r_sp_press <= 1'b0;
            if (r_en_state == RELEASED) begin
                if (w_en_full) begin
                    r_en_state <= PRESSED;
                    r_en_press <= 1'b1;
                    r_en       <= ~r_en;
                end
            end else if (w_en_empty) begin
                r_en_state <= RELEASED;
            end
            if (r_sp_state == RELEASED) begin
                if (w_sp_full) begin
                    r_sp_state <= PRESSED;
                    r_sp_press <= 1'b1;
                    r_speed    <= ~r_speed;
                end
            end else if (w_sp_empty) begin
                r_sp_state <= RELEASED;
            end
        end
    end

    // Step counter keeps running across speed changes; speed only picks the compare width.
    assign w_step_hit = r_speed ? (&r_step_cnt) : (&r_step_cnt[STEP_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
            r_step     <= 1'b0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
            r_step     <= w_step_hit;
        end
    end

    assign en          = r_en;
    assign speed       = r_speed;
    assign step        = r_step;
    assign en_press    = r_en_press;
    assign speed_press = r_sp_press;
    assign dbg_state   = {r_sp_state == PRESSED, r_en_state == PRESSED};

endmodule

// File: tb/tb_led_input_ctrl.sv
// Bench for led_input_ctrl (SAMPLE_W=2, STEP_W=3): hand vector table, directed corner sequences,
// and random button activity compared every cycle against an edge-indexed reference model.
module tb_led_input_ctrl;
  localparam int SAMPLE_W = 2;
  localparam int STEP_W   = 3;
  localparam int SAMPLE_P = 1 << SAMPLE_W;
  localparam int STEP_P   = 1 << STEP_W;
`ifdef LED_INPUT_DBNC_FILTER_EN
  localparam int HIST_N     = 4;
  localparam int PRESS_EDGE = 17;  // held from edge 1 after reset: samples at ticks 4,8,12,16
  localparam int ALIGN_EDGE = 37;  // rise before edge 22: samples at 24,28,32,36
  localparam int ALIGN_STEP = 48;
`else
  localparam int HIST_N     = 1;
  localparam int PRESS_EDGE = 5;
  localparam int ALIGN_EDGE = 25;
  localparam int ALIGN_STEP = 32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_en = 1'b0;
  logic btn_speed = 1'b0;
  logic en, speed, step, en_press, speed_press;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  led_input_ctrl #(.SAMPLE_W(SAMPLE_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .btn_en(btn_en), .btn_speed(btn_speed),
    .en(en), .speed(speed), .step(step), .en_press(en_press),
    .speed_press(speed_press), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int n_pe, n_ps, n_step;

  // Reference model: m_k is the number of clock edges since reset was last seen.
  int m_k;
  bit m_en, m_sp, m_st_en, m_st_sp, m_step, m_pe, m_ps;
  bit raw_en_q[$], raw_sp_q[$], hist_en_q[$], hist_sp_q[$];
  logic [6:0] exp_q[$];

  function automatic bit all_ones(input bit h[$]);
    foreach (h[i]) if (!h[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_zeros(input bit h[$]);
    foreach (h[i]) if (h[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_k = 0;
    {m_en, m_sp, m_st_en, m_st_sp, m_step, m_pe, m_ps} = '0;
    raw_en_q = '{1'b0, 1'b0};
    raw_sp_q = '{1'b0, 1'b0};
    hist_en_q = {};
    hist_sp_q = {};
    for (int i = 0; i < HIST_N; i++) begin
      hist_en_q.push_back(1'b0);
      hist_sp_q.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input bit r, input bit be, input bit bs);
    int period;
    if (r) begin
      model_reset();
    end else begin
      m_k++;
      period = m_sp ? 2 * STEP_P : STEP_P;
      m_step = ((m_k - 1) % period) == period - 1;
      m_pe = !m_st_en && all_ones(hist_en_q);
      if (m_pe) begin m_st_en = 1'b1; m_en = !m_en; end
      else if (m_st_en && all_zeros(hist_en_q)) m_st_en = 1'b0;
      m_ps = !m_st_sp && all_ones(hist_sp_q);
      if (m_ps) begin m_st_sp = 1'b1; m_sp = !m_sp; end
      else if (m_st_sp && all_zeros(hist_sp_q)) m_st_sp = 1'b0;
      // A tick on edge k samples the button as it was two edges earlier.
      if (m_k % SAMPLE_P == 0) begin
        hist_en_q.push_back(raw_en_q[0]); void'(hist_en_q.pop_front());
        hist_sp_q.push_back(raw_sp_q[0]); void'(hist_sp_q.pop_front());
      end
      raw_en_q.push_back(be); void'(raw_en_q.pop_front());
      raw_sp_q.push_back(bs); void'(raw_sp_q.pop_front());
    end
    exp_q.push_back({m_en, m_sp, m_step, m_pe, m_ps, m_st_sp, m_st_en});
  endtask

  task automatic cycle();
    bit r, be, bs;
    logic [6:0] exp_v, got_v;
    r = rst; be = btn_en; bs = btn_speed;
    @(posedge clk);
    #1;
    model_edge(r, be, bs);
    exp_v = exp_q.pop_front();
    got_v = {en, speed, step, en_press, speed_press, dbg_state};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model k=%0d t=%0t got=%b exp=%b (en,speed,step,en_press,speed_press,state[1:0])",
               m_k, $time, got_v, exp_v);
    end
    n_pe += int'(en_press);
    n_ps += int'(speed_press);
    n_step += int'(step);
  endtask

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic wait_pulse(input bit which_sp, input int budget, output int edge_k);
    edge_k = -1;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (which_sp ? speed_press : en_press) begin
        edge_k = m_k;
        break;
      end
    end
  endtask

  task automatic wait_step(input int budget, output int edge_k);
    edge_k = -1;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (step) begin
        edge_k = m_k;
        break;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit r; bit be; bit bs; int n;
    bit e_en; bit e_sp; int e_pe; int e_ps; int e_steps; int max_lat; bit same;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int p, e, e2, first_pe, first_ps;
    int hold_e, hold_s;
    model_reset();

    //          r  be bs  n    en sp pe ps steps lat same
    vecs[0] = '{1, 0, 0,   2,  0, 0, 0, 0,  0,   0,  0};
    vecs[1] = '{0, 0, 0, 100,  0, 0, 0, 0, 12,   0,  0};
    vecs[2] = '{0, 1, 0,  40,  1, 0, 1, 0, -1,  19,  0};
    vecs[3] = '{0, 0, 0,  40,  1, 0, 0, 0, -1,   0,  0};
    vecs[4] = '{0, 1, 1,  40,  0, 1, 1, 1, -1,   0,  1};
    vecs[5] = '{0, 0, 0,  40,  0, 1, 0, 0, -1,   0,  0};
    vecs[6] = '{0, 0, 1,  40,  0, 0, 0, 1, -1,   0,  0};
    vecs[7] = '{0, 0, 0,  40,  0, 0, 0, 0, -1,   0,  0};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].r; btn_en = vecs[i].be; btn_speed = vecs[i].bs;
      n_pe = 0; n_ps = 0; n_step = 0; first_pe = 0; first_ps = 0;
      for (int c = 1; c <= vecs[i].n; c++) begin
        cycle();
        if (en_press && first_pe == 0) first_pe = c;
        if (speed_press && first_ps == 0) first_ps = c;
      end
      chk($sformatf("row%0d_en", i), en, vecs[i].e_en);
      chk($sformatf("row%0d_speed", i), speed, vecs[i].e_sp);
      chk($sformatf("row%0d_en_press_count", i), n_pe, vecs[i].e_pe);
      chk($sformatf("row%0d_speed_press_count", i), n_ps, vecs[i].e_ps);
      if (vecs[i].e_steps >= 0) chk($sformatf("row%0d_step_count", i), n_step, vecs[i].e_steps);
      if (vecs[i].max_lat > 0) chk($sformatf("row%0d_latency_ok", i),
                                   int'(first_pe > 0 && first_pe <= vecs[i].max_lat), 1);
      if (vecs[i].same) chk($sformatf("row%0d_same_cycle", i), first_pe, first_ps);
    end
    rst = 1'b0; btn_en = 1'b0; btn_speed = 1'b0;

    // Chatter toggling every cycle, phased so every sample tick sees a low level.
    do_reset(2);
    n_pe = 0;
    for (int c = 0; c < 60; c++) begin
      btn_en = ((m_k + 1) % 2) == 1;
      cycle();
    end
    btn_en = 1'b0;
    repeat (20) cycle();
    chk("toggle_en_press_count", n_pe, 0);
    chk("toggle_en", en, 0);

    // Speed becomes 1 at step counter value 5; next step when the counter reaches 15.
    do_reset(2);
    while (m_k < 21) cycle();
    btn_speed = 1'b1;
    wait_pulse(1'b1, 60, p);
    chk("align_press_edge", p, ALIGN_EDGE);
    btn_speed = 1'b0;
    wait_step(40, e);
    chk("align_next_step_edge", e, ALIGN_STEP);
    wait_step(40, e2);
    chk("align_slow_period", e2 - e, 2 * STEP_P);

    // Reset while the speed history is partly filled, button kept held.
    do_reset(2);
    btn_speed = 1'b1;
    while (m_k < 10) cycle();
    n_ps = 0;
    do_reset(2);
    chk("rst_mid_speed", speed, 0);
    chk("rst_mid_no_pulse", n_ps, 0);
    wait_pulse(1'b1, 40, p);
    chk("held_after_rst_edge", p, PRESS_EDGE);
    chk("held_after_rst_speed", speed, 1);
    n_ps = 0;
    repeat (30) cycle();
    chk("held_no_repeat", n_ps, 0);

    // Reset landing on the very edge a press would fire.
    do_reset(2);
    while (m_k < PRESS_EDGE - 1) cycle();
    n_ps = 0;
    do_reset(1);
    chk("rst_collide_no_pulse", n_ps, 0);
    chk("rst_collide_speed", speed, 0);
    wait_pulse(1'b1, 40, p);
    chk("rst_collide_repress_edge", p, PRESS_EDGE);
    btn_speed = 1'b0;

    // Random holds and chatter on both buttons, occasional reset.
    hold_e = 0; hold_s = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_e == 0) begin
        btn_en = 1'($urandom_range(0, 1));
        hold_e = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(4, 40));
      end
      if (hold_s == 0) begin
        btn_speed = 1'($urandom_range(0, 1));
        hold_s = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(4, 40));
      end
      hold_e--; hold_s--;
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
